cluster_task_sequencer: RTL and testbench

CLUSTER_TASK_SEQUENCER -- requirements
Module: cluster_task_sequencer

---
 rtl/cluster_task_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cluster_task_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_task_sequencer.sv
// Cluster task sequencer: walks the enabled client slots in ascending order,
// re-arms and starts each one, muxes the active client onto the shared memory
// port, and waits for its done level under an optional watchdog.
module cluster_task_sequencer #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned NSLOT      = 3
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        run,
  input  logic [NSLOT-1:0]            slot_mask,
  input  logic [15:0]                 timeout_limit,
  input  logic [NSLOT*ADDR_WIDTH-1:0] c_addr,
  input  logic [NSLOT-1:0]            c_wr_en,
  input  logic [NSLOT*WORD_WIDTH-1:0] c_data,
  input  logic [NSLOT-1:0]            c_done,
  output logic [NSLOT-1:0]            c_en,
  output logic [NSLOT-1:0]            c_start,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic                        mem_wr_en,
  output logic [WORD_WIDTH-1:0]       mem_data_out,
  output logic                        busy,
  output logic                        seq_done,
  output logic                        timeout_err,
  output logic [1:0]                  err_slot
);

  localparam int unsigned IdxW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef enum logic [2:0] {StIdle, StSelect, StEnable, StStart, StWait, StFinish} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   act_q, act_d;
  logic [NSLOT-1:0]  mask_q, mask_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              terr_q, terr_d;
  logic [1:0]        eslot_q, eslot_d;

  logic [NSLOT-1:0]      act_onehot;
  logic [ADDR_WIDTH-1:0] act_addr;
  logic [WORD_WIDTH-1:0] act_data;
  logic                  act_wr;
  logic                  act_done;
  logic                  found;
  logic [IdxW-1:0]       sel;

  // Extract the active client's fields from the packed buses.
  always_comb begin
    act_onehot = '0;
    act_addr   = '0;
    act_data   = '0;
    act_wr     = 1'b0;
    act_done   = 1'b0;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      if (IdxW'(s) == act_q) begin
        act_onehot[s] = 1'b1;
        act_addr      = c_addr[s*ADDR_WIDTH +: ADDR_WIDTH];
        act_data      = c_data[s*WORD_WIDTH +: WORD_WIDTH];
        act_wr        = c_wr_en[s];
        act_done      = c_done[s];
      end
    end
  end

  // Lowest pending slot at or above the current active index.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      if (!found && (IdxW'(s) >= act_q) && mask_q[s]) begin
        found = 1'b1;
        sel   = IdxW'(s);
      end
    end
  end

  // Next-state logic for the sequencing FSM and its bookkeeping registers.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    eslot_d = eslot_q;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          mask_d  = slot_mask;
          terr_d  = 1'b0;
          act_d   = '0;
          state_d = StSelect;
        end
      end
      StSelect: begin
        if (found) begin
          act_d   = sel;
          state_d = StEnable;
        end else begin
          state_d = StFinish;
        end
      end
      StEnable: state_d = StStart;
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Done takes priority over a watchdog expiry in the same cycle.
        if (act_done) begin
          mask_d  = mask_q & ~act_onehot;
          state_d = StSelect;
        end else if ((timeout_limit != 16'd0) && (cnt_q == timeout_limit - 16'd1)) begin
          terr_d  = 1'b1;
          eslot_d = 2'(act_q);
          mask_d  = mask_q & ~act_onehot;
          state_d = StSelect;
        end else if (timeout_limit != 16'd0) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      act_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      eslot_q <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      eslot_q <= eslot_d;
    end
  end

  // Outputs decode from registered state so reset clears them immediately.
  always_comb begin
    c_en         = '0;
    c_start      = '0;
    mem_addr     = '0;
    mem_data_out = '0;
    mem_wr_en    = 1'b0;
    if (state_q == StEnable) c_en = act_onehot;
    if (state_q == StStart)  c_start = act_onehot;
    if ((state_q == StEnable) || (state_q == StStart) || (state_q == StWait)) begin
      mem_addr     = act_addr;
      mem_data_out = act_data;
    end
    if (state_q == StWait) mem_wr_en = act_wr;
    busy        = (state_q != StIdle);
    seq_done    = (state_q == StFinish);
    timeout_err = terr_q;
    err_slot    = eslot_q;
  end

endmodule

// File: tb/tb_cluster_task_sequencer.sv
// Bench for cluster_task_sequencer: behavioural clients plus a timeline model
// that predicts every output per cycle from the sequencing rules.
module tb_cluster_task_sequencer;

  localparam int NS    = 3;
  localparam int AW    = 11;
  localparam int WW    = 16;
  localparam int NEVER = 100000;

  logic              clock = 1'b0;
  logic              rst;
  logic              run;
  logic [NS-1:0]     slot_mask;
  logic [15:0]       timeout_limit;
  logic [NS*AW-1:0]  c_addr;
  logic [NS-1:0]     c_wr_en;
  logic [NS*WW-1:0]  c_data;
  logic [NS-1:0]     c_done;
  logic [NS-1:0]     c_en;
  logic [NS-1:0]     c_start;
  logic [AW-1:0]     mem_addr;
  logic              mem_wr_en;
  logic [WW-1:0]     mem_data_out;
  logic              busy;
  logic              seq_done;
  logic              timeout_err;
  logic [1:0]        err_slot;

  cluster_task_sequencer #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .NSLOT(NS)) dut (
    .clock(clock), .rst(rst), .run(run), .slot_mask(slot_mask),
    .timeout_limit(timeout_limit), .c_addr(c_addr), .c_wr_en(c_wr_en), .c_data(c_data),
    .c_done(c_done), .c_en(c_en), .c_start(c_start), .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en), .mem_data_out(mem_data_out), .busy(busy), .seq_done(seq_done),
    .timeout_err(timeout_err), .err_slot(err_slot)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Clients: done rises delay cycles after start and holds until the next en.
  int delay[NS];
  bit armed[NS] = '{default: 1'b0};
  int st_cyc[NS] = '{default: 0};
  always @(posedge clock) begin
    for (int s = 0; s < NS; s++) begin
      if (c_start[s]) begin
        armed[s]  <= 1'b1;
        st_cyc[s] <= cyc;
      end else if (c_en[s]) begin
        armed[s] <= 1'b0;
      end
    end
  end
  always_comb begin
    c_done = '0;
    for (int s = 0; s < NS; s++) c_done[s] = armed[s] && (cyc >= st_cyc[s] + delay[s]);
  end

  // Timeline model: per-slot window [lo, hi], WAIT from wt, FINISH at fin.
  bit m_on[NS];
  int m_lo[NS];
  int m_wt[NS];
  int m_hi[NS];
  int m_acc;
  int m_fin;
  bit m_terr;
  int m_eslot = 0;

  function automatic void build_model(input int acc, input logic [NS-1:0] mask,
                                      input logic [15:0] lim);
    int c;
    int d;
    int to;
    m_acc  = acc;
    m_terr = 1'b0;
    c      = acc + 1;
    for (int s = 0; s < NS; s++) begin
      m_on[s] = mask[s];
      if (mask[s]) begin
        m_lo[s] = c + 1;
        m_wt[s] = c + 3;
        d = (delay[s] < 1) ? c + 3 : ((c + 2 + delay[s] > c + 3) ? c + 2 + delay[s] : c + 3);
        to = c + 3 + int'(lim) - 1;
        if (lim != 16'd0 && to < d) begin
          m_hi[s] = to;
          m_terr  = 1'b1;
          m_eslot = s;
        end else begin
          m_hi[s] = d;
        end
        c = m_hi[s] + 1;
      end
    end
    m_fin = c + 1;
  endfunction

  // Per-cycle trace comparison against the model while a sequence is observed.
  bit          mon_on = 1'b0;
  int          mon_bad = 0;
  int          seq_cnt = 0;
  int          mon_first_cyc = 0;
  logic [63:0] mon_got, mon_exp, mon_first_got, mon_first_exp;
  logic [NS-1:0] e_en, e_st;
  logic          e_wr;
  logic [AW-1:0] e_addr;
  logic [WW-1:0] e_data;
  always @(negedge clock) begin
    if (mon_on) begin
      e_en = '0; e_st = '0; e_wr = 1'b0; e_addr = '0; e_data = '0;
      for (int s = 0; s < NS; s++) begin
        if (m_on[s]) begin
          if (cyc == m_lo[s]) e_en[s] = 1'b1;
          if (cyc == m_lo[s] + 1) e_st[s] = 1'b1;
          if (cyc >= m_lo[s] && cyc <= m_hi[s]) begin
            e_addr = c_addr[s*AW +: AW];
            e_data = c_data[s*WW +: WW];
            if (cyc >= m_wt[s]) e_wr = c_wr_en[s];
          end
        end
      end
      mon_exp = 64'({(cyc > m_acc) && (cyc <= m_fin), cyc == m_fin, e_en, e_st, e_wr,
                     e_addr, e_data});
      mon_got = 64'({busy, seq_done, c_en, c_start, mem_wr_en, mem_addr, mem_data_out});
      if (mon_got !== mon_exp) begin
        if (mon_bad == 0) begin
          mon_first_cyc = cyc;
          mon_first_got = mon_got;
          mon_first_exp = mon_exp;
        end
        mon_bad++;
      end
      if (seq_done === 1'b1) seq_cnt++;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic set_clients(input logic [NS-1:0] wr);
    c_addr  = (NS*AW)'({$urandom(), $urandom()});
    c_data  = (NS*WW)'({$urandom(), $urandom()});
    c_wr_en = wr;
  endtask

  task automatic run_seq(input logic [NS-1:0] mask, input logic [15:0] lim, input bit poke,
                         input string tag);
    int bad0;
    int done0;
    @(negedge clock);
    slot_mask     = mask;
    timeout_limit = lim;
    run           = 1'b1;
    build_model(cyc, mask, lim);
    bad0   = mon_bad;
    done0  = seq_cnt;
    mon_on = 1'b1;
    @(posedge clock);
    #1;
    run       = 1'b0;
    slot_mask = NS'($urandom());  // must not matter once latched
    if (poke) begin
      repeat (3) @(negedge clock);
      check({tag, "_busy_at_poke"}, 64'(busy), 64'(1));
      run = 1'b1;
      @(negedge clock);
      run = 1'b0;
    end
    while (cyc < m_fin + 4) @(negedge clock);
    mon_on = 1'b0;
    check({tag, "_trace_mismatches"}, 64'(mon_bad - bad0), 64'(0));
    if (mon_bad != bad0)
      $display("  %s first divergence at cycle %0d got %h want %h", tag, mon_first_cyc,
               mon_first_got, mon_first_exp);
    check({tag, "_seq_done_count"}, 64'(seq_cnt - done0), 64'(1));
    check({tag, "_timeout_err"}, 64'(timeout_err), 64'(m_terr));
    check({tag, "_err_slot"}, 64'(err_slot), 64'(m_eslot));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NS-1:0] mask;
    logic [15:0]   lim;
    rst = 1'b0; run = 1'b0; slot_mask = '0; timeout_limit = '0;
    c_addr = '0; c_wr_en = '0; c_data = '0;
    for (int s = 0; s < NS; s++) delay[s] = 1;
    #1 rst = 1'b1;
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_outputs", 64'({seq_done, c_en, c_start, mem_wr_en, mem_addr, mem_data_out}),
          64'(0));
    check("reset_errors", 64'({timeout_err, err_slot}), 64'(0));
    repeat (3) @(negedge clock);
    rst = 1'b0;

    // All slots, no watchdog, each done 10 cycles after start.
    for (int s = 0; s < NS; s++) delay[s] = 10;
    set_clients(3'b111);
    run_seq(3'b111, 16'd0, 1'b0, "all3");

    // Slot 1 masked out while its write enable is high.
    for (int s = 0; s < NS; s++) delay[s] = $urandom_range(1, 8);
    set_clients(3'b111);
    run_seq(3'b101, 16'd0, 1'b0, "skip1");

    // Empty mask: SELECT then FINISH.
    set_clients(3'b111);
    run_seq(3'b000, 16'd0, 1'b0, "empty");

    // Slot 1 never finishes; watchdog of 5 expires, slot 2 still runs.
    delay[0] = 3; delay[1] = NEVER; delay[2] = 4;
    set_clients(3'b010);
    run_seq(3'b111, 16'd5, 1'b0, "tmo1");
    check("tmo1_err_slot_is_1", 64'(err_slot), 64'(1));

    // Slot 0 done exactly on the expiry cycle; also a run while busy.
    delay[0] = 5; delay[1] = 2; delay[2] = 2;
    set_clients(3'b001);
    run_seq(3'b111, 16'd5, 1'b1, "tie0");
    check("tie0_no_error", 64'(timeout_err), 64'(0));

    // Randomized sequences.
    for (int k = 0; k < 20; k++) begin
      mask = NS'($urandom());
      lim  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      for (int s = 0; s < NS; s++)
        delay[s] = (lim != 16'd0 && $urandom_range(0, 3) == 0) ? NEVER : $urandom_range(1, 15);
      set_clients(NS'($urandom()));
      run_seq(mask, lim, 1'b0, "rand");
    end

    // Reset in WAIT while the active client is writing.
    delay[0] = NEVER;
    set_clients(3'b001);
    @(negedge clock);
    slot_mask = 3'b001; timeout_limit = 16'd0; run = 1'b1;
    @(posedge clock);
    #1 run = 1'b0;
    for (int i = 0; i < 10 && mem_wr_en !== 1'b1; i++) @(negedge clock);
    check("rstwait_wr_before", 64'(mem_wr_en), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("rstwait_wr_dropped", 64'(mem_wr_en), 64'(0));
    check("rstwait_busy", 64'(busy), 64'(0));
    check("rstwait_outputs", 64'({seq_done, c_en, c_start, mem_addr, mem_data_out}), 64'(0));
    check("rstwait_errors", 64'({timeout_err, err_slot}), 64'(0));
    repeat (2) @(negedge clock);
    check("rstwait_held_idle", 64'({busy, seq_done}), 64'(0));
    rst = 1'b0;
    m_eslot = 0;

    // Normal operation resumes after the abort.
    delay[0] = 2; delay[1] = 3; delay[2] = NEVER;
    set_clients(3'b111);
    run_seq(3'b111, 16'd4, 1'b0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
